multi_timer: RTL and testbench
==============================

Name: multi_timer

Overview:
- Parametrised multi-channel countdown timer: CHANNELS independent down-counters, each WIDTH bits wide.
- Each channel runs one-shot or periodic (auto-reload) and raises busy while counting plus a one-cycle done pulse at expiry.
- Sits beside control FSMs that need several timeouts or periodic ticks at once; a single load port is shared by all channels.

Parameters:
- WIDTH, 16, counter width per channel.
- CHANNELS, 4, number of independent channels (>=1).
- PRESCALE_W, 8, prescaler divisor width (used only with the optional feature).
- CH_W, derived localparam = max(1, $clog2(CHANNELS)), channel index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- load  in  1  load strobe for channel load_ch.
- load_ch  in  CH_W  target channel for load.
- load_cycles  in  WIDTH  count value; 0 means ignore the load.
- load_periodic  in  1  0 = one-shot, 1 = periodic auto-reload.
- stop  in  1  abort strobe for channel stop_ch.
- stop_ch  in  CH_W  target channel for stop.
- busy  out  CHANNELS  per channel: counter != 0.
- done  out  CHANNELS  per channel: registered one-cycle expiry pulse.
- prescale_div  in  PRESCALE_W  present only with TIMER_PRESCALE_EN.

Behaviour:
- Reset is synchronous and active-high, sampled on clk. On reset, every channel gets counter=0, reload=0, periodic=0, done=0; busy=0 and the prescaler is cleared. Reset overrides all other inputs, including mid-count.
- Per-channel state: counter[WIDTH], reload[WIDTH], periodic flag. busy[i] is combinational from counter[i]; done[i] is a register.
- A tick qualifies decrements. Without the optional feature, tick=1 every cycle.
- Priority per channel per cycle: reset > load (addressed, load_cycles!=0) > stop (addressed) > tick countdown.
- Load at edge N:
  - counter=reload=load_cycles; periodic=load_periodic.
  - busy is high from edge N onward.
  - Loading a busy channel restarts it with no done pulse.
  - load_cycles==0: no state change; it does not stop a running channel.
  - load_ch >= CHANNELS: ignored.
- Stop: counter=0, periodic=0, no done pulse. Stopping an idle channel, or stop_ch >= CHANNELS, is a no-op.
- Simultaneous load and stop on the same channel: load wins. On different channels both take effect.
- Countdown on tick when counter>0:
  - counter>1: counter-1.
  - counter==1, one-shot: counter=0, done=1 for exactly the next cycle.
  - counter==1, periodic: counter=reload, done=1 for one cycle, busy stays high.
- done is 0 in every other cycle.
- One-shot timing with tick=1: load C at edge N gives busy high for exactly C cycles. done is high in the cycle after edge N+C, the same cycle busy falls. No wrap below 0.
- Periodic timing with tick=1: done pulses every C cycles, first pulse C cycles after load. Period C=1 gives done high every cycle.
- Channels are fully independent. No ordering or arbitration exists between channel expiries.

Optional Feature:
- Macro TIMER_PRESCALE_EN.
- Defined:
  - A shared PRESCALE_W-bit prescaler counts up from 0 each cycle.
  - When pcount >= prescale_div: tick=1 and pcount=0 on that edge.
  - The tick period is prescale_div+1 cycles; prescale_div=0 gives tick every cycle.
  - Load does not resynchronise the prescaler, so the first decrement occurs 1..prescale_div+1 cycles after load. Subsequent decrements are exactly prescale_div+1 apart.
  - Changing prescale_div takes effect on the next comparison. Reset clears pcount.
- Undefined: port prescale_div is absent, tick is tied to 1, and there is no prescaler logic.

Decomposition:
- Package timer_pkg holds:
  - Mode constants TIMER_ONESHOT=1'b0 and TIMER_PERIODIC=1'b1.
  - The default WIDTH, CHANNELS and PRESCALE_W values.
- Sub-module timer_channel, one instance per channel via generate, holds counter/reload/periodic/done. Its inputs are clk, reset, tick, ld, ld_cycles, ld_periodic and stp.
- The top level decodes load_ch/stop_ch and owns the prescaler.

Test Plan:
- Reset during count: load ch0 C=100, assert reset at cycle 20 -> next cycle busy=0, done=0 on all channels, no done pulse afterwards.
- One-shot: load ch1 C=5 at edge N -> busy[1] high cycles N..N+4, done[1] high only in cycle after edge N+5, busy[1]=0 then.
- Periodic: load ch2 C=3 periodic -> done[2] pulses every 3 cycles for 10 periods, busy[2] never drops. Then stop ch2 -> busy[2]=0 next cycle, no further done.
- Edge cases:
  - load C=0 on running ch0 -> ch0 continues unchanged.
  - load and stop ch3 same cycle -> ch3 loaded.
  - reload busy ch1 with C=7 mid-count -> restart, no done pulse.
- Independence: load all 4 channels C=4,3,2,1 in consecutive cycles -> all done pulses land on the same cycle, busy mask steps 1111->0000.
- TIMER_PRESCALE_EN, prescale_div=3: load C=2 one-shot -> decrements exactly 4 cycles apart, done within 5..8 cycles of load.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants for the multi-channel countdown timer.
package timer_pkg;

  localparam logic TIMER_ONESHOT  = 1'b0;
  localparam logic TIMER_PERIODIC = 1'b1;

  localparam int unsigned TIMER_WIDTH      = 16;
  localparam int unsigned TIMER_CHANNELS   = 4;
  localparam int unsigned TIMER_PRESCALE_W = 8;

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: one-shot or auto-reload, with a registered one-cycle done pulse.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_cycles_i,
  input  logic             ld_periodic_i,
  input  logic             stp_i,
  output logic             busy_o,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             periodic_q, periodic_d;
  logic             done_q, done_d;

  always_comb begin
    count_d    = count_q;
    reload_d   = reload_q;
    periodic_d = periodic_q;
    done_d     = 1'b0;
    if (ld_i) begin
      count_d    = ld_cycles_i;
      reload_d   = ld_cycles_i;
      periodic_d = ld_periodic_i;
    end else if (stp_i) begin
      count_d    = '0;
      periodic_d = TIMER_ONESHOT;
    end else if (tick_i && (count_q != '0)) begin
      if (count_q == WIDTH'(1)) begin
        done_d  = 1'b1;
        count_d = (periodic_q == TIMER_PERIODIC) ? reload_q : '0;
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      reload_q   <= '0;
      periodic_q <= TIMER_ONESHOT;
      done_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      reload_q   <= reload_d;
      periodic_q <= periodic_d;
      done_q     <= done_d;
    end
  end

  assign busy_o = (count_q != '0);
  assign done_o = done_q;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel countdown timer with a shared load/stop port.
// Optional shared prescaler enabled by defining TIMER_PRESCALE_EN.
module multi_timer
  import timer_pkg::*;
#(
  parameter  int unsigned WIDTH      = TIMER_WIDTH,
  parameter  int unsigned CHANNELS   = TIMER_CHANNELS,
  parameter  int unsigned PRESCALE_W = TIMER_PRESCALE_W,
  localparam int unsigned CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic [CH_W-1:0]       load_ch_i,
  input  logic [WIDTH-1:0]      load_cycles_i,
  input  logic                  load_periodic_i,
  input  logic                  stop_i,
  input  logic [CH_W-1:0]       stop_ch_i,
`ifdef TIMER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale_div_i,
`endif
  output logic [CHANNELS-1:0]   busy_o,
  output logic [CHANNELS-1:0]   done_o
);

  logic tick;

`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] pcount_q, pcount_d;

  // Free-running; loads do not resynchronise it.
  always_comb begin
    tick     = (pcount_q >= prescale_div_i);
    pcount_d = tick ? '0 : pcount_q + PRESCALE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcount_q <= '0;
    end else begin
      pcount_q <= pcount_d;
    end
  end
`else
  logic unused_prescale_w;
  assign unused_prescale_w = (PRESCALE_W != 0);
  assign tick = 1'b1;
`endif

  logic load_valid;
  assign load_valid = load_i && (load_cycles_i != '0);

  // Out-of-range channel indices never match, so they are ignored.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic ld, stp;
    assign ld  = load_valid && (load_ch_i == CH_W'(i));
    assign stp = stop_i && (stop_ch_i == CH_W'(i));

    timer_channel #(
      .WIDTH(WIDTH)
    ) u_channel (
      .clk          (clk),
      .reset        (reset),
      .tick_i       (tick),
      .ld_i         (ld),
      .ld_cycles_i  (load_cycles_i),
      .ld_periodic_i(load_periodic_i),
      .stp_i        (stp),
      .busy_o       (busy_o[i]),
      .done_o       (done_o[i])
    );
  end

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: table of single-cycle vectors plus multi-cycle sequences.
module tb_multi_timer;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned CHANNELS = 4;
  localparam int unsigned CH_W     = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             load;
  logic [CH_W-1:0]  load_ch;
  logic [WIDTH-1:0] load_cycles;
  logic             load_periodic;
  logic             stop;
  logic [CH_W-1:0]  stop_ch;
  logic [7:0]       prescale_div;
  logic [CHANNELS-1:0] busy, done;

  int total = 0;
  int passed = 0;

  multi_timer #(
    .WIDTH     (WIDTH),
    .CHANNELS  (CHANNELS),
    .PRESCALE_W(8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .load_i         (load),
    .load_ch_i      (load_ch),
    .load_cycles_i  (load_cycles),
    .load_periodic_i(load_periodic),
    .stop_i         (stop),
    .stop_ch_i      (stop_ch),
`ifdef TIMER_PRESCALE_EN
    .prescale_div_i (prescale_div),
`endif
    .busy_o         (busy),
    .done_o         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             ld;
    logic [CH_W-1:0]  ch;
    logic [WIDTH-1:0] cyc;
    logic             per;
    logic             st;
    logic [CH_W-1:0]  sch;
    logic [3:0]       exp_busy;
    logic [3:0]       exp_done;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic ld, input int ch, input int cyc, input logic per,
                     input logic st, input int sch, input logic [3:0] eb, input logic [3:0] ed);
    vec_t v;
    v.ld = ld; v.ch = CH_W'(ch); v.cyc = WIDTH'(cyc); v.per = per;
    v.st = st; v.sch = CH_W'(sch); v.exp_busy = eb; v.exp_done = ed;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    load = 1'b0; load_ch = '0; load_cycles = '0; load_periodic = 1'b0;
    stop = 1'b0; stop_ch = '0;
  endtask

  // Drive one cycle of inputs, then sample just after the edge.
  task automatic cycle(input logic ld, input int ch, input int cyc, input logic per,
                       input logic st, input int sch);
    load = ld; load_ch = CH_W'(ch); load_cycles = WIDTH'(cyc); load_periodic = per;
    stop = st; stop_ch = CH_W'(sch);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    int k;
    logic seen;
    idle_inputs();
    prescale_div = 8'd3;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    reset = 1'b0;

`ifndef TIMER_PRESCALE_EN
    // ld ch cyc per st sch busy done
    add(0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    // one-shot ch1 C=5
    add(1, 1, 5, 0, 0, 0, 4'b0010, 4'b0000);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 4'b0010, 4'b0000);
    add(0, 0, 0, 0, 0, 0, 4'b0000, 4'b0010);
    add(0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    // load C=0 does not disturb running ch0
    add(1, 0, 3, 0, 0, 0, 4'b0001, 4'b0000);
    add(1, 0, 0, 0, 0, 0, 4'b0001, 4'b0000);
    add(0, 0, 0, 0, 0, 0, 4'b0001, 4'b0000);
    add(0, 0, 0, 0, 0, 0, 4'b0000, 4'b0001);
    // load and stop same channel: load wins
    add(1, 3, 2, 0, 1, 3, 4'b1000, 4'b0000);
    add(0, 0, 0, 0, 0, 0, 4'b1000, 4'b0000);
    add(0, 0, 0, 0, 0, 0, 4'b0000, 4'b1000);
    // load and stop on different channels, stop gives no pulse
    add(1, 0, 2, 0, 1, 3, 4'b0001, 4'b0000);
    add(1, 1, 3, 0, 1, 0, 4'b0010, 4'b0000);
    add(0, 0, 0, 0, 1, 1, 4'b0000, 4'b0000);
    add(0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    // reload busy ch1 mid-count
    add(1, 1, 2, 0, 0, 0, 4'b0010, 4'b0000);
    add(1, 1, 7, 0, 0, 0, 4'b0010, 4'b0000);
    for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 0, 0, 4'b0010, 4'b0000);
    add(0, 0, 0, 0, 0, 0, 4'b0000, 4'b0010);
    // staggered loads expire together
    add(1, 0, 4, 0, 0, 0, 4'b0001, 4'b0000);
    add(1, 1, 3, 0, 0, 0, 4'b0011, 4'b0000);
    add(1, 2, 2, 0, 0, 0, 4'b0111, 4'b0000);
    add(1, 3, 1, 0, 0, 0, 4'b1111, 4'b0000);
    add(0, 0, 0, 0, 0, 0, 4'b0000, 4'b1111);
    add(0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);

    foreach (vecs[i]) begin
      cycle(vecs[i].ld, int'(vecs[i].ch), int'(vecs[i].cyc), vecs[i].per,
            vecs[i].st, int'(vecs[i].sch));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
    end

    // Periodic ch2 C=3 for 10 periods, then stop
    cycle(1, 2, 3, 1, 0, 0);
    for (int c = 1; c <= 30; c++) begin
      cycle(0, 0, 0, 0, 0, 0);
      chk($sformatf("per_busy_%0d", c), 32'(busy[2]), 32'h1);
      chk($sformatf("per_done_%0d", c), 32'(done[2]), (c % 3 == 0) ? 32'h1 : 32'h0);
    end
    cycle(0, 0, 0, 0, 1, 2);
    chk("per_stop_busy", 32'(busy), 32'h0);
    chk("per_stop_done", 32'(done), 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cycle(0, 0, 0, 0, 0, 0);
      seen = seen | done[2];
    end
    chk("per_after_stop_done", 32'(seen), 32'h0);

    // Period 1 pulses every cycle
    cycle(1, 0, 1, 1, 0, 0);
    chk("p1_busy0", 32'(busy), 32'h1);
    for (int c = 1; c <= 4; c++) begin
      cycle(0, 0, 0, 0, 0, 0);
      chk($sformatf("p1_done_%0d", c), 32'(done), 32'h1);
      chk($sformatf("p1_busy_%0d", c), 32'(busy), 32'h1);
    end
    cycle(0, 0, 0, 0, 1, 0);
    chk("p1_stop_busy", 32'(busy), 32'h0);
    chk("p1_stop_done", 32'(done), 32'h0);
`endif

    // Reset during count
    cycle(1, 0, 100, 0, 0, 0);
    for (int c = 0; c < 18; c++) cycle(0, 0, 0, 0, 0, 0);
    chk("rst_pre_busy", 32'(busy[0]), 32'h1);
    reset = 1'b1;
    cycle(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_done", 32'(done), 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 120; c++) begin
      cycle(0, 0, 0, 0, 0, 0);
      seen = seen | (|done) | (|busy);
    end
    chk("rst_quiet_after", 32'(seen), 32'h0);

`ifdef TIMER_PRESCALE_EN
    // prescale_div=3: done lands 5..8 cycles after load
    cycle(1, 0, 2, 0, 0, 0);
    chk("ps_busy_load", 32'(busy[0]), 32'h1);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      cycle(0, 0, 0, 0, 0, 0);
      k++;
      seen = done[0];
    end
    chk("ps_done_seen", 32'(seen), 32'h1);
    chk("ps_done_window", 32'((k >= 5) && (k <= 8)), 32'h1);
    cycle(0, 0, 0, 0, 0, 0);
    chk("ps_done_one_cycle", 32'(done[0]), 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
